// File: rtl/mem_rd_resp.sv
// Read-side responder for the core data bus: snoops core stores into a local word RAM
// and serves one load at a time (RAM or synchronized switch port) with a 2-cycle latency.
module mem_rd_resp #(
  parameter int          DEPTH   = 256,
  parameter logic [31:0] IN_ADDR = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic        wr_we,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        rd_ready,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        rd_err,
  output logic        drop,
  input  logic [15:0] data_in
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {IDLE, READ, RESP} state_e;

  // Handshake: a request is taken on an edge where rd_req=1 and rd_ready=1; the answer
  // is a single-cycle rd_valid pulse, and rd_req seen while rd_ready=0 only sets drop.
  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        drop_q, drop_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_err_q, rd_err_d;
  logic [15:0] sync1_q, sync1_d;
  logic [15:0] sync2_q, sync2_d;
  logic        sel_ram_q, sel_ram_d;
  logic        sel_in_q, sel_in_d;
  logic [15:0] in_word_q, in_word_d;
  logic [31:0] ram_rdata_q;

  logic [31:0] mem [DEPTH];

  // RAM has no reset; stores are snooped in every state.
  always_ff @(posedge clk) begin
    if (wr_we && (wr_addr < DEPTH_W)) begin
      mem[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  // Read-first: a store landing on the same edge as this read is not returned.
  always_ff @(posedge clk) begin
    if (state_q == READ) begin
      ram_rdata_q <= mem[addr_q[AW-1:0]];
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    drop_d     = drop_q | (rd_req && (state_q != IDLE));
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_err_d   = 1'b0;
    sync1_d    = data_in;
    sync2_d    = sync1_q;
    sel_ram_d  = sel_ram_q;
    sel_in_d   = sel_in_q;
    in_word_d  = in_word_q;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          addr_d  = rd_addr;
          state_d = READ;
        end
      end
      READ: begin
        sel_ram_d = addr_q < DEPTH_W;
        sel_in_d  = addr_q == IN_ADDR;
        in_word_d = sync2_q;
        state_d   = RESP;
      end
      RESP: begin
        rd_valid_d = 1'b1;
        rd_err_d   = !(sel_ram_q || sel_in_q);
        if (sel_ram_q) begin
          rd_data_d = ram_rdata_q;
        end else if (sel_in_q) begin
          rd_data_d = {16'h0000, in_word_q};
        end else begin
          rd_data_d = 32'h0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= 32'h0;
      drop_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 32'h0;
      rd_err_q   <= 1'b0;
      sync1_q    <= 16'h0;
      sync2_q    <= 16'h0;
      sel_ram_q  <= 1'b0;
      sel_in_q   <= 1'b0;
      in_word_q  <= 16'h0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      drop_q     <= drop_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_err_q   <= rd_err_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sel_ram_q  <= sel_ram_d;
      sel_in_q   <= sel_in_d;
      in_word_q  <= in_word_d;
    end
  end

  assign rd_ready = (state_q == IDLE);
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_err   = rd_err_q;
  assign drop     = drop_q;

endmodule

// File: tb/tb_mem_rd_resp.sv
// Bench for mem_rd_resp: directed loads/stores; expected responses are queued at issue
// time and a negedge monitor pops and checks data, error flag and arrival cycle.
module tb_mem_rd_resp;

  localparam logic [31:0] IN_ADDR = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
  logic        wr_we, rd_req, rd_ready, rd_valid, rd_err, drop;
  logic [15:0] data_in;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  logic [32:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [32:0] exp_e;
  int          exp_c;

  mem_rd_resp #(.DEPTH(256), .IN_ADDR(IN_ADDR)) dut (
    .clk(clk), .rst(rst),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_we(wr_we),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
    .drop(drop), .data_in(data_in)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drivers
  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    wr_we = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_we = 1'b0;
  endtask

  // Request is accepted on the next edge (cyc+1); the strobe is seen at cyc+3.
  task automatic expect_resp(input logic [31:0] d, input logic e, input int at);
    exp_q.push_back({e, d});
    exp_cyc_q.push_back(at);
  endtask

  // wr_phase: 0 none, 1 store in the accept cycle, 2 store during READ.
  task automatic read(input logic [31:0] a, input logic [31:0] d, input logic e,
                      input int wr_phase, input logic [31:0] wa, input logic [31:0] wd);
    check("ready_before_req", {31'h0, rd_ready}, 32'h1);
    expect_resp(d, e, cyc + 3);
    rd_req = 1'b1; rd_addr = a;
    if (wr_phase == 1) begin wr_we = 1'b1; wr_addr = wa; wr_data = wd; end
    tick();
    rd_req = 1'b0; wr_we = 1'b0;
    if (wr_phase == 2) begin wr_we = 1'b1; wr_addr = wa; wr_data = wd; end
    tick();
    wr_we = 1'b0;
    tick();
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_valid: rd_valid=1 data=%h at cycle %0d, required no response", rd_data, cyc);
      end else begin
        exp_e = exp_q.pop_front();
        exp_c = exp_cyc_q.pop_front();
        check("rd_data", rd_data, exp_e[31:0]);
        check("rd_err", {31'h0, rd_err}, {31'h0, exp_e[32]});
        check("resp_cycle", 32'(cyc), 32'(exp_c));
      end
    end
  end

  initial begin
    rst = 1'b1; rd_req = 1'b0; rd_addr = '0;
    wr_we = 1'b0; wr_addr = '0; wr_data = '0; data_in = '0;
    tick(); tick();
    check("rst_rd_ready", {31'h0, rd_ready}, 32'h1);
    check("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
    check("rst_rd_err",   {31'h0, rd_err},   32'h0);
    check("rst_drop",     {31'h0, drop},     32'h0);
    check("rst_rd_data",  rd_data,           32'h0);
    rst = 1'b0;

    write_word(32'd0, 32'h0000_CAFE);
    write_word(32'd3, 32'h3333_3333);
    write_word(32'd6, 32'h6666_6666);

    // Basic store then load
    write_word(32'd5, 32'hDEAD_BEEF);
    read(32'd5, 32'hDEAD_BEEF, 1'b0, 0, '0, '0);
    check("drop_after_basic", {31'h0, drop}, 32'h0);

    // Same-cycle store visible, in-flight store hidden, then visible
    read(32'd7, 32'd1, 1'b0, 1, 32'd7, 32'd1);
    read(32'd7, 32'd1, 1'b0, 2, 32'd7, 32'd2);
    read(32'd7, 32'd2, 1'b0, 0, '0, '0);

    // Switch port through the synchronizer
    data_in = 16'hA5C3;
    tick(); tick(); tick();
    read(IN_ADDR, 32'h0000_A5C3, 1'b0, 0, '0, '0);
    data_in = 16'h1234;
    read(IN_ADDR, 32'h0000_A5C3, 1'b0, 0, '0, '0);
    tick(); tick(); tick();
    read(IN_ADDR, 32'h0000_1234, 1'b0, 0, '0, '0);

    // Unmapped loads and ignored stores
    read(32'h0000_0100, 32'h0, 1'b1, 0, '0, '0);
    read(32'hFFFF_FFFF, 32'h0, 1'b1, 0, '0, '0);
    write_word(IN_ADDR, 32'hFFFF_FFFF);
    write_word(32'h0000_0100, 32'hBAD0_BAD0);
    read(32'd0, 32'h0000_CAFE, 1'b0, 0, '0, '0);
    read(IN_ADDR, 32'h0000_1234, 1'b0, 0, '0, '0);

    // Back-to-back requests: only addresses 0, 3, 6 are taken
    check("drop_before_burst", {31'h0, drop}, 32'h0);
    expect_resp(32'h0000_CAFE, 1'b0, cyc + 3);
    expect_resp(32'h3333_3333, 1'b0, cyc + 6);
    expect_resp(32'h6666_6666, 1'b0, cyc + 9);
    for (int i = 0; i < 9; i++) begin
      rd_req = 1'b1; rd_addr = 32'(i);
      tick();
      if (i == 0) check("drop_first_cycle", {31'h0, drop}, 32'h0);
      if (i == 1) check("drop_second_cycle", {31'h0, drop}, 32'h1);
    end
    rd_req = 1'b0;
    tick(); tick(); tick();
    check("drop_sticky", {31'h0, drop}, 32'h1);

    // Reset during READ abandons the load
    check("ready_before_abort", {31'h0, rd_ready}, 32'h1);
    rd_req = 1'b1; rd_addr = 32'd5;
    tick();
    rd_req = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_rd_ready", {31'h0, rd_ready}, 32'h1);
    check("abort_drop",     {31'h0, drop},     32'h0);
    check("abort_rd_valid", {31'h0, rd_valid}, 32'h0);
    check("abort_rd_data",  rd_data,           32'h0);
    tick(); tick(); tick();
    read(32'd5, 32'hDEAD_BEEF, 1'b0, 0, '0, '0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("pending_responses", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
